// File: rtl/ultrasonido_pkg.sv
// Shared types, default 50 MHz timing and the round-robin channel picker
// used by the ultrasonic scheduler.
package ultrasonido_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIGGER,
    WAIT_RISE,
    MEASURE,
    GUARD
  } state_t;

  localparam int MAX_SENSORS            = 8;
  localparam int DEFAULT_TRIG_CYCLES    = 500;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1_500_000;
  localparam int DEFAULT_GUARD_CYCLES   = 3_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // First enabled channel strictly after current, wrapping at n; holds current if none.
  function automatic logic [2:0] next_enabled_index(input logic [MAX_SENSORS-1:0] mask,
                                                    input logic [2:0] current,
                                                    input int n);
    logic [2:0] result;
    logic       found;
    int         cand;
    result = current;
    found  = 1'b0;
    for (int k = 1; k <= MAX_SENSORS; k++) begin
      cand = (int'(current) + k) % n;
      if (!found && k <= n && mask[cand[2:0]]) begin
        result = cand[2:0];
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ultrasonido_echo_sync.sv
// Two-flop synchronizer for the asynchronous echo pins with rising and
// falling edge pulses taken from the synchronized level.
module ultrasonido_echo_sync
  import ultrasonido_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] echo,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= '0;
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      meta_reg <= echo;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/ultrasonido_scheduler.sv
// Round-robin HC-SR04 scheduler: trigger, echo timing, timeout and guard per channel.
// Optional minimum-distance tracking is built when ULTRASONIDO_SCHEDULER_MIN_TRACK_EN is defined.
module ultrasonido_scheduler
  import ultrasonido_pkg::*;
#(
  parameter int NUM_SENSORS    = 4,
  parameter int DATAWIDTH      = 16,
  parameter int TRIG_CYCLES    = DEFAULT_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GUARD_CYCLES   = DEFAULT_GUARD_CYCLES
) (
  input  logic                             Ultrasonido_Scheduler_Clock,
  input  logic                             Ultrasonido_Scheduler_Reset,
  input  logic [NUM_SENSORS-1:0]           Ultrasonido_Scheduler_Enable_In,
  input  logic [NUM_SENSORS-1:0]           Ultrasonido_Scheduler_Echo_In,
  output logic [NUM_SENSORS-1:0]           Ultrasonido_Scheduler_Trigger_Out,
  output logic [NUM_SENSORS*DATAWIDTH-1:0] Ultrasonido_Scheduler_Conteo_Out,
  output logic [NUM_SENSORS-1:0]           Ultrasonido_Scheduler_Timeout_Out,
  output logic                             Ultrasonido_Scheduler_Valid_Out,
  output logic [$clog2(NUM_SENSORS)-1:0]   Ultrasonido_Scheduler_Index_Out,
`ifdef ULTRASONIDO_SCHEDULER_MIN_TRACK_EN
  output logic [DATAWIDTH-1:0]             Ultrasonido_Scheduler_Min_Out,
  output logic [$clog2(NUM_SENSORS)-1:0]   Ultrasonido_Scheduler_Min_Index_Out,
`endif
  output logic                             Ultrasonido_Scheduler_Busy_Out
);

  localparam int IDX_W = $clog2(NUM_SENSORS);
  localparam int TMR_W = $clog2(max3(TRIG_CYCLES, TIMEOUT_CYCLES, GUARD_CYCLES)) + 1;
  localparam logic [DATAWIDTH-1:0] COUNT_MAX = '1;

  logic clk;
  logic srst;
  assign clk  = Ultrasonido_Scheduler_Clock;
  assign srst = Ultrasonido_Scheduler_Reset;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     index_reg, index_next;
  logic [TMR_W-1:0]     timer_reg, timer_next;
  logic [DATAWIDTH-1:0] count_reg, count_next;
  logic                 wr_en;
  logic [DATAWIDTH-1:0] wr_value;
  logic                 wr_timeout;
  logic [DATAWIDTH-1:0] conteo_reg [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] timeout_reg;
  logic                 valid_reg;
  logic [IDX_W-1:0]     valid_index_reg;
  logic [NUM_SENSORS-1:0] echo_rise;
  logic [NUM_SENSORS-1:0] echo_fall;

  ultrasonido_echo_sync #(.WIDTH(NUM_SENSORS)) u_echo_sync (
    .clk  (clk),
    .srst (srst),
    .echo (Ultrasonido_Scheduler_Echo_In),
    .rise (echo_rise),
    .fall (echo_fall)
  );

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    timer_next = timer_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_value   = '0;
    wr_timeout = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (|Ultrasonido_Scheduler_Enable_In) begin
          index_next = IDX_W'(next_enabled_index(MAX_SENSORS'(Ultrasonido_Scheduler_Enable_In),
                                                 3'(index_reg), NUM_SENSORS));
          timer_next = '0;
          state_next = TRIGGER;
        end
      end
      TRIGGER: begin
        if (timer_reg == TMR_W'(TRIG_CYCLES - 1)) begin
          timer_next = '0;
          state_next = WAIT_RISE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT_RISE: begin
        // The edge cycle is the first high cycle, so it already counts as 1.
        if (echo_rise[index_reg]) begin
          count_next = DATAWIDTH'(1);
          state_next = MEASURE;
        end else if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          wr_en      = 1'b1;
          wr_value   = COUNT_MAX;
          wr_timeout = 1'b1;
          timer_next = '0;
          state_next = GUARD;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall[index_reg]) begin
          wr_en      = 1'b1;
          wr_value   = count_reg;
          timer_next = '0;
          state_next = GUARD;
        end else if (count_reg == COUNT_MAX) begin
          wr_en      = 1'b1;
          wr_value   = COUNT_MAX;
          wr_timeout = 1'b1;
          timer_next = '0;
          state_next = GUARD;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      GUARD: begin
        // The IDLE arbitration cycle completes the guard interval.
        if (timer_reg == TMR_W'(GUARD_CYCLES - 2)) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg       <= IDLE;
      index_reg       <= IDX_W'(NUM_SENSORS - 1);
      timer_reg       <= '0;
      count_reg       <= '0;
      timeout_reg     <= '0;
      valid_reg       <= 1'b0;
      valid_index_reg <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        conteo_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      timer_reg <= timer_next;
      count_reg <= count_next;
      valid_reg <= wr_en;
      if (wr_en) begin
        conteo_reg[index_reg]  <= wr_value;
        timeout_reg[index_reg] <= wr_timeout;
        valid_index_reg        <= index_reg;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_out
    assign Ultrasonido_Scheduler_Trigger_Out[gi] = (state_reg == TRIGGER) && (index_reg == IDX_W'(gi));
    assign Ultrasonido_Scheduler_Conteo_Out[gi*DATAWIDTH +: DATAWIDTH] = conteo_reg[gi];
  end

  assign Ultrasonido_Scheduler_Timeout_Out = timeout_reg;
  assign Ultrasonido_Scheduler_Valid_Out   = valid_reg;
  assign Ultrasonido_Scheduler_Index_Out   = valid_index_reg;
  assign Ultrasonido_Scheduler_Busy_Out    = (state_reg != IDLE);

`ifdef ULTRASONIDO_SCHEDULER_MIN_TRACK_EN
  logic [DATAWIDTH-1:0] min_value, min_reg;
  logic [IDX_W-1:0]     min_index, min_index_reg;
  logic                 min_found;

  // Strict less-than while scanning upward keeps ties on the lower index.
  always_comb begin
    min_value = '1;
    min_index = '0;
    min_found = 1'b0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (Ultrasonido_Scheduler_Enable_In[i] && !timeout_reg[i] &&
          (!min_found || conteo_reg[i] < min_value)) begin
        min_value = conteo_reg[i];
        min_index = IDX_W'(i);
        min_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      min_reg       <= '0;
      min_index_reg <= '0;
    end else if (valid_reg) begin
      min_reg       <= min_value;
      min_index_reg <= min_index;
    end
  end

  assign Ultrasonido_Scheduler_Min_Out       = min_reg;
  assign Ultrasonido_Scheduler_Min_Index_Out = min_index_reg;
`endif

endmodule
